// File: rtl/pcie_req_tlp_parser.sv
// Decodes single-DW MRd/MWr TLPs popped from the PCIe request CDC FIFO.
// Define PCIE_REQ_TLP_PARSER_DROPCNT_EN to add the o_drop_cnt output.
module pcie_req_tlp_parser #(
    parameter int DROP_CNT_W = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_fifo_rd,
    input  logic [72:0] i_fifo_rdata,
    input  logic        i_fifo_empty,
    output logic        o_req_valid,
    input  logic        i_req_ready,
    output logic        o_req_write,
    output logic        o_req_64,
    output logic [63:0] o_req_addr,
    output logic [31:0] o_req_wdata,
    output logic [3:0]  o_req_be,
    output logic [15:0] o_req_rid,
    output logic [7:0]  o_req_tag,
    output logic [2:0]  o_req_tc,
    output logic [1:0]  o_req_attr,
    output logic        o_busy
`ifdef PCIE_REQ_TLP_PARSER_DROPCNT_EN
    ,
    output logic [DROP_CNT_W-1:0] o_drop_cnt
`endif
);

    typedef enum logic [2:0] {
        S_H0, S_H1, S_H2, S_DROP, S_OUT
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  fmt_q, fmt_d;
    logic [2:0]  tc_q, tc_d;
    logic [1:0]  attr_q, attr_d;
    logic [15:0] rid_q, rid_d;
    logic [7:0]  tag_q, tag_d;
    logic [3:0]  be_q, be_d;
    logic [63:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        valid_q, valid_d;
    logic        busy_q, busy_d;
    logic        drop_evt;

    logic        last;
    logic [31:0] odd;
    logic [31:0] even;
    logic        pop;
    logic        supported;

    assign last = i_fifo_rdata[72];
    assign odd  = i_fifo_rdata[63:32];
    assign even = i_fifo_rdata[31:0];
    assign pop  = !i_fifo_empty && (state_q != S_OUT);

    // fmt 000..011 are the 3DW/4DW no-data/with-data memory request forms
    assign supported = (even[31] == 1'b0) && (even[28:24] == 5'b0)
                    && (even[9:0] == 10'd1) && !even[14];

    always_comb begin
        state_d  = state_q;
        fmt_d    = fmt_q;
        tc_d     = tc_q;
        attr_d   = attr_q;
        rid_d    = rid_q;
        tag_d    = tag_q;
        be_d     = be_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        drop_evt = 1'b0;
        unique case (state_q)
            S_H0: if (pop) begin
                fmt_d   = even[31:29];
                tc_d    = even[22:20];
                attr_d  = even[13:12];
                rid_d   = odd[31:16];
                tag_d   = odd[15:8];
                be_d    = odd[3:0];
                addr_d  = 64'h0;
                wdata_d = 32'h0;
                if (!supported || last) begin
                    drop_evt = 1'b1;
                    state_d  = last ? S_H0 : S_DROP;
                end else begin
                    state_d = S_H1;
                end
            end
            S_H1: if (pop) begin
                if (fmt_q[0]) begin
                    addr_d = {even, odd[31:2], 2'b00};
                end else begin
                    addr_d = {32'h0, even[31:2], 2'b00};
                    if (fmt_q[1]) wdata_d = odd;
                end
                if (last && !(fmt_q[0] && fmt_q[1])) begin
                    state_d = S_OUT;
                end else if (!last && fmt_q[0] && fmt_q[1]) begin
                    state_d = S_H2;
                end else begin
                    drop_evt = 1'b1;
                    state_d  = last ? S_H0 : S_DROP;
                end
            end
            S_H2: if (pop) begin
                wdata_d = even;
                if (last) begin
                    state_d = S_OUT;
                end else begin
                    drop_evt = 1'b1;
                    state_d  = S_DROP;
                end
            end
            S_DROP: if (pop && last) state_d = S_H0;
            S_OUT: if (i_req_ready) state_d = S_H0;
            default: state_d = S_H0;
        endcase
        valid_d = (state_d == S_OUT);
        busy_d  = (state_d != S_H0);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_H0;
            fmt_q   <= '0;
            tc_q    <= '0;
            attr_q  <= '0;
            rid_q   <= '0;
            tag_q   <= '0;
            be_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            fmt_q   <= fmt_d;
            tc_q    <= tc_d;
            attr_q  <= attr_d;
            rid_q   <= rid_d;
            tag_q   <= tag_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign o_fifo_rd   = pop;
    assign o_req_valid = valid_q;
    assign o_req_write = fmt_q[1];
    assign o_req_64    = fmt_q[0];
    assign o_req_addr  = addr_q;
    assign o_req_wdata = wdata_q;
    assign o_req_be    = be_q;
    assign o_req_rid   = rid_q;
    assign o_req_tag   = tag_q;
    assign o_req_tc    = tc_q;
    assign o_req_attr  = attr_q;
    assign o_busy      = busy_q;

`ifdef PCIE_REQ_TLP_PARSER_DROPCNT_EN
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop_evt && (drop_cnt_q != {DROP_CNT_W{1'b1}}))
            drop_cnt_d = drop_cnt_q + 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) drop_cnt_q <= '0;
        else       drop_cnt_q <= drop_cnt_d;
    end

    assign o_drop_cnt = drop_cnt_q;
`else
    logic                  unused_drop;
    logic [DROP_CNT_W-1:0] unused_cnt;
    assign unused_drop = drop_evt;
    assign unused_cnt  = '0;
`endif

    // keep and reserved header bits carry nothing this block needs
    logic unused_bits;
    assign unused_bits = ^{i_fifo_rdata[71:64], even[23], even[19:15],
                           even[11:10], odd[7:4]};

endmodule
